// File: rtl/ov2640_config_sequencer_if.sv
// Init-ROM read port and SCCB register-write request bundle for the OV2640 sequencer.
// master = sequencer side, slave = ROM / SCCB engine side.
interface ov2640_config_sequencer_if;
  logic [7:0]  rom_addr;
  logic [17:0] rom_data;
  logic        wr_valid;
  logic [7:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        wr_accept;

  modport master (
    output rom_addr,
    input  rom_data,
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_accept
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_accept
  );
endinterface

// File: rtl/ov2640_config_sequencer.sv
// Walks the OV2640 init table (write / ms-delay / end entries) and feeds the SCCB write engine.
// One request at a time; wr_valid held until wr_accept or the accept timeout, then a fixed guard time.
module ov2640_config_sequencer #(
  parameter int INIT_DELAY_CYCLES = 480000,
  parameter int WRITE_CYCLES      = 65536,
  parameter int DELAY_UNIT        = 24000,
  parameter int ACCEPT_TIMEOUT    = 131072,
  parameter int ROM_DEPTH         = 256
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  ov2640_config_sequencer_if.master        bus,
  output logic                             busy,
  output logic                             done,
  output logic                             error
);

  localparam logic [2:0] S_PWR_WAIT = 3'd0;
  localparam logic [2:0] S_FETCH    = 3'd1;
  localparam logic [2:0] S_DECODE   = 3'd2;
  localparam logic [2:0] S_ISSUE    = 3'd3;
  localparam logic [2:0] S_SETTLE   = 3'd4;
  localparam logic [2:0] S_DELAY    = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;
  localparam logic [2:0] S_ERROR    = 3'd7;

  localparam logic [7:0]  LAST_INDEX = 8'(ROM_DEPTH - 1);
  localparam logic [31:0] INIT_LAST  = 32'(INIT_DELAY_CYCLES - 1);
  localparam logic [31:0] SETTLE_LD  = 32'(WRITE_CYCLES - 1);
  localparam logic [31:0] TIMEOUT    = 32'(ACCEPT_TIMEOUT);

  logic [2:0]  state;
  logic [7:0]  index;
  logic [31:0] cnt;
  // Set when the final table slot was a write: its SETTLE ends in DONE instead of FETCH.
  logic        tail;
  logic        wr_valid_q;
  logic [7:0]  wr_addr_q;
  logic [7:0]  wr_data_q;

  logic [1:0]  rom_cmd;
  logic [7:0]  rom_reg;
  logic [7:0]  rom_val;

  assign rom_cmd = bus.rom_data[17:16];
  assign rom_reg = bus.rom_data[15:8];
  assign rom_val = bus.rom_data[7:0];

  assign bus.rom_addr = index;
  assign bus.wr_valid = wr_valid_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;

  assign busy  = (state != S_DONE) && (state != S_ERROR);
  assign done  = (state == S_DONE);
  assign error = (state == S_ERROR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_PWR_WAIT;
      index      <= 8'd0;
      cnt        <= 32'd0;
      tail       <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 8'd0;
      wr_data_q  <= 8'd0;
    end else begin
      case (state)
        S_PWR_WAIT: begin
          if (cnt == INIT_LAST) begin
            cnt   <= 32'd0;
            index <= 8'd0;
            state <= S_FETCH;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          case (rom_cmd)
            2'b00: begin
              wr_addr_q  <= rom_reg;
              wr_data_q  <= rom_val;
              wr_valid_q <= 1'b1;
              cnt        <= 32'd0;
              state      <= S_ISSUE;
            end
            2'b01: begin
              if (rom_val == 8'd0) begin
                if (index == LAST_INDEX) begin
                  state <= S_DONE;
                end else begin
                  index <= index + 8'd1;
                  state <= S_FETCH;
                end
              end else begin
                cnt   <= 32'(DELAY_UNIT) * {24'd0, rom_val} - 32'd1;
                state <= S_DELAY;
              end
            end
            default: state <= S_DONE;
          endcase
        end
        S_ISSUE: begin
          // Accept is checked first so a same-cycle accept beats the timeout.
          if (bus.wr_accept) begin
            wr_valid_q <= 1'b0;
            cnt        <= SETTLE_LD;
            state      <= S_SETTLE;
            if (index == LAST_INDEX) begin
              tail <= 1'b1;
            end else begin
              index <= index + 8'd1;
            end
          end else if (cnt == TIMEOUT) begin
            wr_valid_q <= 1'b0;
            state      <= S_ERROR;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_SETTLE: begin
          if (cnt == 32'd0) begin
            state <= tail ? S_DONE : S_FETCH;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        S_DELAY: begin
          if (cnt == 32'd0) begin
            if (index == LAST_INDEX) begin
              state <= S_DONE;
            end else begin
              index <= index + 8'd1;
              state <= S_FETCH;
            end
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        default: begin
          if (start) begin
            index <= 8'd0;
            tail  <= 1'b0;
            state <= S_FETCH;
          end
        end
      endcase
    end
  end

endmodule
